// File: rtl/forthsuper_pkg.sv
// -----------------------------------------------------------------------------
// forthsuper_pkg
// Shared types for the Forth data-stack datapath:
//   stack_ops_e : operation code understood by the stack memory (PUSH/POP/READ)
//   stk_cmd_e   : data-stack primitive issued by the instruction decoder
//   stk_state_e : stack_ctl sequencer state
//   LAT_*       : accept-to-done latency of each primitive class, in cycles
// -----------------------------------------------------------------------------
package forthsuper_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_READ = 2'd2
    } stack_ops_e;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_PUSH = 3'd1,
        CMD_DROP = 3'd2,
        CMD_DUP  = 3'd3,
        CMD_SWAP = 3'd4,
        CMD_OVER = 3'd5,
        CMD_ROT  = 3'd6
    } stk_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_E1   = 3'd1,
        ST_E2   = 3'd2,
        ST_E3   = 3'd3,
        ST_E4   = 3'd4
    } stk_state_e;

    // NOP/PUSH/DUP/short DROP and rejected commands
    localparam int unsigned LAT_SHORT = 32'd2;
    // DROP (depth>=2), SWAP, OVER
    localparam int unsigned LAT_MED   = 32'd3;
    // ROT
    localparam int unsigned LAT_ROT   = 32'd5;

endpackage

// File: rtl/stack_ctl.sv
// -----------------------------------------------------------------------------
// stack_ctl
// Sequencer executing Forth data-stack primitives over a single-port stack
// memory with one-cycle read latency. TOS is cached in r_tos; the memory
// holds only the entries below TOS.
//
// Optional feature macro: STK_CHECK_EN
//   defined   : commands violating depth/capacity rules are rejected (no
//               memory access, tos/depth kept) and the sticky err flag is set.
//   undefined : every command executes; depth wraps; err stays 0.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   en           : gates command acceptance only
//   req, cmd, vi : decoder request, primitive (7 = NOP), PUSH operand
//   rdy, done    : idle / one-cycle completion pulse
//   tos, depth   : top of stack, entry count including TOS
//   err          : sticky overflow/underflow flag
//   m_op, m_en, m_vi, m_vo : stack memory port (m_vo valid the cycle after
//                            a POP/READ is issued)
// -----------------------------------------------------------------------------
module stack_ctl
    import forthsuper_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           req,
    input  logic [2:0]     cmd,
    input  logic [DSZ-1:0] vi,
    output logic           rdy,
    output logic           done,
    output logic [DSZ-1:0] tos,
    output logic [SSZ:0]   depth,
    output logic           err,
    output stack_ops_e     m_op,
    output logic           m_en,
    output logic [DSZ-1:0] m_vi,
    input  logic [DSZ-1:0] m_vo
);

    localparam logic [SSZ:0] DEP_ZERO  = {(SSZ+1){1'b0}};
    localparam logic [SSZ:0] DEP_ONE   = (SSZ+1)'(32'd1);
    localparam logic [SSZ:0] DEP_TWO   = (SSZ+1)'(32'd2);
    localparam logic [SSZ:0] DEP_THREE = (SSZ+1)'(32'd3);
    localparam logic [SSZ:0] DEP_MAX   = (SSZ+1)'(DEPTH);

    stk_state_e     r_state;
    stk_cmd_e       r_cmd;
    logic [DSZ-1:0] r_vi;
    logic [DSZ-1:0] r_tos;
    logic [SSZ:0]   r_depth;
    logic [DSZ-1:0] r_t1;
    logic           r_rdy;
    logic           r_done;
    logic           r_err;
    stack_ops_e     r_m_op;
    logic           r_m_en;
    logic [DSZ-1:0] r_m_vi;

    stk_cmd_e       w_cmd;
    logic           w_accept;
    logic           w_legal;

    assign w_cmd    = (cmd == 3'd7) ? CMD_NOP : stk_cmd_e'(cmd);
    assign w_accept = req & r_rdy & en;

`ifdef STK_CHECK_EN
    // Depth/capacity precondition of the command currently offered.
    always_comb begin
        w_legal = 1'b1;
        case (w_cmd)
            CMD_PUSH: w_legal = (r_depth < DEP_MAX);
            CMD_DUP:  w_legal = (r_depth >= DEP_ONE) && (r_depth < DEP_MAX);
            CMD_DROP: w_legal = (r_depth >= DEP_ONE);
            CMD_SWAP: w_legal = (r_depth >= DEP_TWO);
            CMD_OVER: w_legal = (r_depth >= DEP_TWO) && (r_depth < DEP_MAX);
            CMD_ROT:  w_legal = (r_depth >= DEP_THREE);
            default:  w_legal = 1'b1;
        endcase
    end
`else
    assign w_legal = 1'b1;
`endif

    // Sequencer: all state and all outputs are registered here. Memory
    // control for stage En is loaded on the edge that enters En, so the
    // memory sees the operation during that stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NOP;
            r_vi    <= {DSZ{1'b0}};
            r_tos   <= {DSZ{1'b0}};
            r_depth <= DEP_ZERO;
            r_t1    <= {DSZ{1'b0}};
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_m_op  <= OP_READ;
            r_m_en  <= 1'b0;
            r_m_vi  <= {DSZ{1'b0}};
        end else begin
            r_done <= 1'b0;
            r_m_op <= OP_READ;
            r_m_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rdy   <= 1'b0;
                        r_state <= ST_E1;
                        r_vi    <= vi;
                        r_err   <= r_err | ~w_legal;
                        // A rejected command runs as a one-stage NOP.
                        r_cmd   <= w_legal ? w_cmd : CMD_NOP;
                        if (w_legal) begin
                            case (w_cmd)
                                CMD_PUSH: begin
                                    // Spill the old TOS only if there is one.
                                    if (r_depth != DEP_ZERO) begin
                                        r_m_op <= OP_PUSH;
                                        r_m_en <= 1'b1;
                                        r_m_vi <= r_tos;
                                    end
                                end
                                CMD_DUP: begin
                                    r_m_op <= OP_PUSH;
                                    r_m_en <= 1'b1;
                                    r_m_vi <= r_tos;
                                end
                                CMD_DROP: begin
                                    // Single entry lives only in r_tos.
                                    if (r_depth != DEP_ONE) begin
                                        r_m_op <= OP_POP;
                                        r_m_en <= 1'b1;
                                    end
                                end
                                CMD_SWAP, CMD_ROT: begin
                                    r_m_op <= OP_POP;
                                    r_m_en <= 1'b1;
                                end
                                // OVER peeks with the idle READ (m_en low).
                                default: ;
                            endcase
                        end
                    end
                end
                ST_E1: begin
                    case (r_cmd)
                        CMD_PUSH: begin
                            r_tos   <= r_vi;
                            r_depth <= r_depth + DEP_ONE;
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                        CMD_DUP: begin
                            r_depth <= r_depth + DEP_ONE;
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                        CMD_DROP: begin
                            if (r_depth == DEP_ONE) begin
                                r_tos   <= {DSZ{1'b0}};
                                r_depth <= DEP_ZERO;
                                r_state <= ST_IDLE;
                                r_rdy   <= 1'b1;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_E2;
                            end
                        end
                        CMD_SWAP, CMD_OVER: begin
                            r_m_op  <= OP_PUSH;
                            r_m_en  <= 1'b1;
                            r_m_vi  <= r_tos;
                            r_state <= ST_E2;
                        end
                        CMD_ROT: begin
                            r_m_op  <= OP_POP;
                            r_m_en  <= 1'b1;
                            r_state <= ST_E2;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    endcase
                end
                ST_E2: begin
                    case (r_cmd)
                        CMD_DROP: begin
                            r_tos   <= m_vo;
                            r_depth <= r_depth - DEP_ONE;
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                        CMD_SWAP: begin
                            r_tos   <= m_vo;
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                        CMD_OVER: begin
                            r_tos   <= m_vo;
                            r_depth <= r_depth + DEP_ONE;
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                        CMD_ROT: begin
                            // m_vo is b here; r_m_vi doubles as the t0 holder
                            // since its only use is the E3 write-back.
                            r_m_op  <= OP_PUSH;
                            r_m_en  <= 1'b1;
                            r_m_vi  <= m_vo;
                            r_state <= ST_E3;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    endcase
                end
                ST_E3: begin
                    if (r_cmd == CMD_ROT) begin
                        // m_vo is a (from the E2 POP); c goes back under it.
                        r_t1    <= m_vo;
                        r_m_op  <= OP_PUSH;
                        r_m_en  <= 1'b1;
                        r_m_vi  <= r_tos;
                        r_state <= ST_E4;
                    end else begin
                        r_state <= ST_IDLE;
                        r_rdy   <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                ST_E4: begin
                    r_tos   <= r_t1;
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b1;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign rdy   = r_rdy;
    assign done  = r_done;
    assign tos   = r_tos;
    assign depth = r_depth;
    assign err   = r_err;
    assign m_op  = r_m_op;
    assign m_en  = r_m_en;
    assign m_vi  = r_m_vi;

endmodule

// File: tb/tb_stack_ctl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctl
// Self-checking bench for stack_ctl (DEPTH=4) with a behavioural single-port
// stack memory attached. Expected results of each command are queued when
// the command is driven and compared when done pulses.
// Honours STK_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_stack_ctl;
    import forthsuper_pkg::*;

    localparam int DEPTH = 4;
    localparam int DSZ   = 32;
    localparam int SSZ   = $clog2(DEPTH);

    logic           clk;
    logic           rst;
    logic           en;
    logic           req;
    logic [2:0]     cmd;
    logic [DSZ-1:0] vi;
    logic           rdy;
    logic           done;
    logic [DSZ-1:0] tos;
    logic [SSZ:0]   depth;
    logic           err;
    stack_ops_e     m_op;
    logic           m_en;
    logic [DSZ-1:0] m_vi;
    logic [DSZ-1:0] m_vo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DSZ-1:0] tos;
        logic [SSZ:0]   depth;
        int             lat;
        bit             chk_tos;
    } exp_t;
    exp_t exp_q[$];

    stack_ctl #(.DEPTH(DEPTH), .DSZ(DSZ), .SSZ(SSZ)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .cmd(cmd), .vi(vi),
        .rdy(rdy), .done(done), .tos(tos), .depth(depth), .err(err),
        .m_op(m_op), .m_en(m_en), .m_vi(m_vi), .m_vo(m_vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack memory: registered read data, reset on rst.
    logic [DSZ-1:0] mem [0:DEPTH-1];
    logic [SSZ-1:0] msp;
    logic [DSZ-1:0] wr_q[$];
    int             men_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            msp  <= {SSZ{1'b0}};
            m_vo <= {DSZ{1'b0}};
        end else if (m_en && m_op == OP_PUSH) begin
            mem[msp] <= m_vi;
            msp      <= msp + 1'b1;
            wr_q.push_back(m_vi);
        end else if (m_en && m_op == OP_POP) begin
            m_vo <= mem[msp - 1'b1];
            msp  <= msp - 1'b1;
        end else if (!m_en && m_op == OP_READ) begin
            m_vo <= mem[msp - 1'b1];
        end
        if (m_en) men_cnt <= men_cnt + 1;
    end

    // Drive one command at the current (rdy) cycle, queue its expectation,
    // then compare once done pulses. Latency counts the accept cycle as 0.
    task automatic issue(input logic [2:0] c, input logic [DSZ-1:0] v,
                         input logic [DSZ-1:0] et, input logic [SSZ:0] ed,
                         input int elat, input bit chk_tos);
        exp_t e;
        exp_t g;
        int lat;
        e.tos = et; e.depth = ed; e.lat = elat; e.chk_tos = chk_tos;
        exp_q.push_back(e);
        req = 1'b1; cmd = c; vi = v;
        @(posedge clk); #1;
        req = 1'b0; cmd = 3'd0; vi = {DSZ{1'b0}};
        lat = 1;
        while (done !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        g = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout cmd=%0d waited=%0d required_lat=%0d", c, lat, g.lat);
        end else begin
            if (lat != g.lat) begin
                failures++;
                $display("FAIL latency cmd=%0d got=%0d required=%0d", c, lat, g.lat);
            end
            if (g.chk_tos) begin
                checks++;
                if (tos !== g.tos) begin
                    failures++;
                    $display("FAIL tos cmd=%0d got=%0h required=%0h", c, tos, g.tos);
                end
            end
            checks++;
            if (depth !== g.depth) begin
                failures++;
                $display("FAIL depth cmd=%0d got=%0d required=%0d", c, depth, g.depth);
            end
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("FAIL rdy_at_done cmd=%0d got=%0b required=1", c, rdy);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; req = 1'b0; cmd = 3'd0; vi = {DSZ{1'b0}};
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({rdy, done, tos, depth, err, m_en} !== {1'b1, 1'b0, {DSZ{1'b0}}, {(SSZ+1){1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b done=%0b tos=%0h depth=%0d err=%0b m_en=%0b required 1 0 0 0 0 0",
                     rdy, done, tos, depth, err, m_en);
        end
        checks++;
        if (m_op !== OP_READ) begin
            failures++;
            $display("FAIL reset_m_op got=%0d required=%0d", m_op, OP_READ);
        end
        rst = 1'b0;
    endtask

    task automatic test_push;
        int n0;
        n0 = wr_q.size();
        issue(CMD_PUSH, 32'd5, 32'd5, 3'd1, 2, 1'b1);
        issue(CMD_PUSH, 32'd7, 32'd7, 3'd2, 2, 1'b1);
        issue(CMD_PUSH, 32'd9, 32'd9, 3'd3, 2, 1'b1);
        checks++;
        if (wr_q.size() != n0 + 2 || wr_q[n0] !== 32'd5 || wr_q[n0+1] !== 32'd7) begin
            failures++;
            $display("FAIL push_mem_writes got_count=%0d required_count=2 (values 5,7)", wr_q.size() - n0);
        end
    endtask

    task automatic test_swap_over_drop;
        issue(CMD_SWAP, 32'd0, 32'd7, 3'd3, 3, 1'b1);
        checks++;
        if (mem[msp - 1'b1] !== 32'd9) begin
            failures++;
            $display("FAIL swap_mem_top got=%0h required=9", mem[msp - 1'b1]);
        end
        issue(CMD_OVER, 32'd0, 32'd9, 3'd4, 3, 1'b1);
        issue(CMD_DROP, 32'd0, 32'd7, 3'd3, 3, 1'b1);
    endtask

    task automatic test_rot;
        test_reset();
        issue(CMD_PUSH, 32'd1, 32'd1, 3'd1, 2, 1'b1);
        issue(CMD_PUSH, 32'd2, 32'd2, 3'd2, 2, 1'b1);
        issue(CMD_PUSH, 32'd3, 32'd3, 3'd3, 2, 1'b1);
        issue(CMD_ROT,  32'd0, 32'd1, 3'd3, 5, 1'b1);
        issue(CMD_DROP, 32'd0, 32'd3, 3'd2, 3, 1'b1);
        issue(CMD_DROP, 32'd0, 32'd2, 3'd1, 3, 1'b1);
    endtask

    task automatic test_drop_underflow;
        int c0;
        c0 = men_cnt;
        issue(CMD_DROP, 32'd0, 32'd0, 3'd0, 2, 1'b1);
        checks++;
        if (men_cnt != c0) begin
            failures++;
            $display("FAIL drop_one_no_mem got_m_en_cycles=%0d required=0", men_cnt - c0);
        end
`ifdef STK_CHECK_EN
        issue(CMD_DROP, 32'd0, 32'd0, 3'd0, 2, 1'b1);
        checks++;
        if (err !== 1'b1 || men_cnt != c0) begin
            failures++;
            $display("FAIL underflow_err got err=%0b m_en_cycles=%0d required err=1 cycles=0", err, men_cnt - c0);
        end
`else
        issue(CMD_DROP, 32'd0, 32'd0, {(SSZ+1){1'b1}}, 3, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL underflow_err_tied got=%0b required=0", err);
        end
`endif
    endtask

    task automatic test_capacity;
        int n0;
        test_reset();
        issue(CMD_PUSH, 32'd1, 32'd1, 3'd1, 2, 1'b1);
        issue(CMD_PUSH, 32'd2, 32'd2, 3'd2, 2, 1'b1);
        issue(CMD_PUSH, 32'd3, 32'd3, 3'd3, 2, 1'b1);
        issue(CMD_PUSH, 32'd4, 32'd4, 3'd4, 2, 1'b1);
        checks++;
        if (done !== 1'b1 || rdy !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_window got done=%0b rdy=%0b required 1 1", done, rdy);
        end
        n0 = wr_q.size();
`ifdef STK_CHECK_EN
        issue(CMD_PUSH, 32'hAA, 32'd4, 3'd4, 2, 1'b1);
        checks++;
        if (err !== 1'b1 || wr_q.size() != n0) begin
            failures++;
            $display("FAIL overflow_err got err=%0b writes=%0d required err=1 writes=0", err, wr_q.size() - n0);
        end
`else
        issue(CMD_PUSH, 32'hAA, 32'hAA, 3'd5, 2, 1'b1);
        checks++;
        if (err !== 1'b0 || wr_q.size() != n0 + 1) begin
            failures++;
            $display("FAIL overflow_unchecked got err=%0b writes=%0d required err=0 writes=1", err, wr_q.size() - n0);
        end
`endif
    endtask

    task automatic test_rst_mid_rot;
        test_reset();
        issue(CMD_PUSH, 32'd1, 32'd1, 3'd1, 2, 1'b1);
        issue(CMD_PUSH, 32'd2, 32'd2, 3'd2, 2, 1'b1);
        issue(CMD_PUSH, 32'd3, 32'd3, 3'd3, 2, 1'b1);
        req = 1'b1; cmd = CMD_ROT;
        @(posedge clk); #1;          // E1
        req = 1'b0; cmd = 3'd0;
        @(posedge clk); #1;          // E2
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rdy, done, tos, depth, err, m_en} !== {1'b1, 1'b0, {DSZ{1'b0}}, {(SSZ+1){1'b0}}, 1'b0, 1'b0}
            || m_op !== OP_READ) begin
            failures++;
            $display("FAIL rst_mid_rot got rdy=%0b done=%0b tos=%0h depth=%0d err=%0b m_en=%0b m_op=%0d required 1 0 0 0 0 0 READ",
                     rdy, done, tos, depth, err, m_en, m_op);
        end
        rst = 1'b0;
        issue(CMD_PUSH, 32'd3, 32'd3, 3'd1, 2, 1'b1);
    endtask

    task automatic test_en_and_busy;
        int bad;
        // DUP accepted, en drops while it is in flight.
        req = 1'b1; cmd = CMD_DUP;
        @(posedge clk); #1;
        req = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || tos !== 32'd3 || depth !== 3'd2) begin
            failures++;
            $display("FAIL dup_en_low got done=%0b tos=%0h depth=%0d required 1 3 2", done, tos, depth);
        end
        // Requests while en is low are not accepted.
        bad = 0;
        req = 1'b1; cmd = CMD_PUSH; vi = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rdy !== 1'b1 || done !== 1'b0 || depth !== 3'd2) bad++;
        end
        req = 1'b0; en = 1'b1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL en_low_blocks got_bad_cycles=%0d required=0", bad);
        end
        issue(CMD_PUSH, 32'd4, 32'd4, 3'd3, 2, 1'b1);
        issue(CMD_PUSH, 32'd8, 32'd8, 3'd4, 2, 1'b1);
        // SWAP with req held high while busy: no second command queued.
        req = 1'b1; cmd = CMD_SWAP;
        @(posedge clk); #1;          // E1
        cmd = CMD_PUSH; vi = 32'h77;
        @(posedge clk); #1;          // E2
        req = 1'b0; cmd = 3'd0;
        @(posedge clk); #1;          // done
        checks++;
        if (done !== 1'b1 || tos !== 32'd4 || depth !== 3'd4) begin
            failures++;
            $display("FAIL swap_busy got done=%0b tos=%0h depth=%0d required 1 4 4", done, tos, depth);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || rdy !== 1'b1 || depth !== 3'd4) begin
            failures++;
            $display("FAIL no_queue got done=%0b rdy=%0b depth=%0d required 0 1 4", done, rdy, depth);
        end
        issue(3'd7, 32'd0, 32'd4, 3'd4, 2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_push();
        test_swap_over_drop();
        test_rot();
        test_drop_underflow();
        test_capacity();
        test_rst_mid_rot();
        test_en_and_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
